alu_op_sequencer: RTL and testbench

- Initiator side of the alu32 operand/control interface.
- Accepts one ALU request per transaction (ALUOp, funct, two operands) over a valid/ready handshake.
- Decodes the request to the 3-bit gin code, drives alu32 with registered operands, captures sum/zout, and returns the result over a valid/ready response handshake.
- Sits between the multi-cycle datapath controller and the combinational alu32 instance.

---
 rtl/alu_op_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Initiator side of the alu32 operand/control interface. One ALU request is
// accepted per transaction, decoded to the alu32 gin code, presented to alu32
// for exactly one EXEC cycle from registered operands, and the captured
// sum/zout is returned on a response handshake.
//
// Handshake semantics (both channels): a transfer happens on the rising edge
// where valid and ready are both 1. req_ready depends only on the FSM state.
// rsp_valid depends only on the FSM state. Neither depends combinationally on
// the opposite side's valid/ready input. Once rsp_valid is high, rsp_* stay
// stable until the transfer edge.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  request handshake
//   req_aluop            00=add, 01=sub, 10=use funct, 11=illegal
//   req_funct            R-type funct field
//   req_a, req_b         operands
//   alu_a, alu_b, alu_gin  drive to alu32 (0/0/010 outside EXEC)
//   alu_sum, alu_zout    results from alu32
//   rsp_valid/rsp_ready  response handshake
//   rsp_result, rsp_zero, rsp_err  captured result, zero flag, illegal flag
//   chk_mismatch         (only with ALU_OP_SEQUENCER_CHECK_EN) sticky flag set
//                        when alu32 disagrees with the internal model in EXEC
//
// Optional feature macro: ALU_OP_SEQUENCER_CHECK_EN
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_aluop,
  input  logic [FUNCT_W-1:0] req_funct,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_gin,
  input  logic [WIDTH-1:0]   alu_sum,
  input  logic               alu_zout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_zero,
  output logic               rsp_err
`ifdef ALU_OP_SEQUENCER_CHECK_EN
  ,
  output logic               chk_mismatch
`endif
);

  localparam logic [2:0] GIN_AND = 3'b000;
  localparam logic [2:0] GIN_OR  = 3'b001;
  localparam logic [2:0] GIN_ADD = 3'b010;
  localparam logic [2:0] GIN_SUB = 3'b110;
  localparam logic [2:0] GIN_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       gin_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;

  logic [2:0] dec_gin;
  logic       dec_legal;

  // Request decode to the alu32 gin code.
  always_comb begin
    dec_gin   = GIN_ADD;
    dec_legal = 1'b1;
    case (req_aluop)
      2'b00: dec_gin = GIN_ADD;
      2'b01: dec_gin = GIN_SUB;
      2'b10: begin
        if (req_funct == FUNCT_W'(6'b100000))      dec_gin = GIN_ADD;
        else if (req_funct == FUNCT_W'(6'b100010)) dec_gin = GIN_SUB;
        else if (req_funct == FUNCT_W'(6'b100100)) dec_gin = GIN_AND;
        else if (req_funct == FUNCT_W'(6'b100101)) dec_gin = GIN_OR;
        else if (req_funct == FUNCT_W'(6'b101010)) dec_gin = GIN_SLT;
        else                                       dec_legal = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) state_next = dec_legal ? EXEC : RESP;
      end
      EXEC:    state_next = RESP;
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: operands latched on accept, result captured in EXEC.
  // An illegal request zeroes result/zero at the accept edge since it never
  // passes through EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      gin_q    <= GIN_ADD;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q      <= req_a;
            b_q      <= req_b;
            gin_q    <= dec_gin;
            err_q    <= ~dec_legal;
            result_q <= '0;
            zero_q   <= 1'b0;
          end
        end
        EXEC: begin
          result_q <= alu_sum;
          zero_q   <= alu_zout;
        end
        default: ;
      endcase
    end
  end

  // Outputs depend only on state and registers, so req_* cannot glitch them.
  always_comb begin
    req_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
    rsp_result = result_q;
    rsp_zero   = zero_q;
    rsp_err    = err_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_gin    = GIN_ADD;
    if (state == EXEC) begin
      alu_a   = a_q;
      alu_b   = b_q;
      alu_gin = gin_q;
    end
  end

`ifdef ALU_OP_SEQUENCER_CHECK_EN
  logic [WIDTH-1:0] model_diff;
  logic [WIDTH-1:0] model_sum;
  logic             model_zero;

  // Reference for the latched operation; slt is the sign bit of a-b, matching
  // alu32 (including its behaviour on signed overflow).
  always_comb begin
    model_diff = a_q - b_q;
    model_sum  = '0;
    case (gin_q)
      GIN_ADD: model_sum = a_q + b_q;
      GIN_SUB: model_sum = model_diff;
      GIN_AND: model_sum = a_q & b_q;
      GIN_OR:  model_sum = a_q | b_q;
      GIN_SLT: model_sum = {{(WIDTH-1){1'b0}}, model_diff[WIDTH-1]};
      default: model_sum = '0;
    endcase
    model_zero = (model_sum == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_mismatch <= 1'b0;
    end else if (state == EXEC &&
                 (alu_sum != model_sum || alu_zout != model_zero)) begin
      chk_mismatch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Bench for alu_op_sequencer. A behavioural alu32 stand-in drives alu_sum and
// alu_zout. Expected responses come from an operation-level reference model
// (aluop/funct -> operation -> arithmetic) and are queued in exp_q.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_aluop;
  logic [5:0]   req_funct;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_gin;
  logic [W-1:0] alu_sum;
  logic         alu_zout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_err;
`ifdef ALU_OP_SEQUENCER_CHECK_EN
  logic         chk_mismatch;
`endif

  alu_op_sequencer #(.WIDTH(W), .FUNCT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_aluop  (req_aluop),
    .req_funct  (req_funct),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_gin    (alu_gin),
    .alu_sum    (alu_sum),
    .alu_zout   (alu_zout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
`ifdef ALU_OP_SEQUENCER_CHECK_EN
    ,
    .chk_mismatch (chk_mismatch)
`endif
  );

  // ---------------- alu32 stand-in ----------------
  logic [W-1:0] alu_diff;
  always_comb begin
    alu_diff = alu_a - alu_b;
    case (alu_gin)
      3'b010:  alu_sum = alu_a + alu_b;
      3'b110:  alu_sum = alu_diff;
      3'b000:  alu_sum = alu_a & alu_b;
      3'b001:  alu_sum = alu_a | alu_b;
      3'b111:  alu_sum = {31'd0, alu_diff[31]};
      default: alu_sum = '0;
    endcase
    alu_zout = (alu_sum == '0);
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [W+1:0] exp_q[$];   // {err, zero, result}

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Operation-level reference: which instruction, then its arithmetic.
  function automatic void ref_model(input logic [1:0] op, input logic [5:0] f,
                                    input logic [W-1:0] a, input logic [W-1:0] b,
                                    output bit legal, output logic [2:0] gin,
                                    output logic [W-1:0] res);
    logic [W-1:0] d;
    d = a - b;
    legal = 1'b1; gin = 3'b010; res = '0;
    if (op == 2'b00 || (op == 2'b10 && f == 6'h20)) begin gin = 3'b010; res = a + b; end
    else if (op == 2'b01 || (op == 2'b10 && f == 6'h22)) begin gin = 3'b110; res = d; end
    else if (op == 2'b10 && f == 6'h24) begin gin = 3'b000; res = a & b; end
    else if (op == 2'b10 && f == 6'h25) begin gin = 3'b001; res = a | b; end
    else if (op == 2'b10 && f == 6'h2A) begin gin = 3'b111; res = {31'd0, d[31]}; end
    else legal = 1'b0;
    if (!legal) res = '0;
  endfunction

  // ---------------- driver ----------------
  // Called at a non-edge time while the DUT is IDLE; returns at a negedge with
  // the DUT IDLE again (or, with overlap=1, with req_valid left high so the
  // next call's request arrives on the edge right after the response).
  task automatic run_txn(input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input bit overlap);
    bit           legal;
    logic [2:0]   gin;
    logic [W-1:0] res;
    logic [W+1:0] e;
    ref_model(op, f, a, b, legal, gin, res);
    exp_q.push_back({~legal, legal && (res == '0), res});
    req_valid = 1'b1; req_aluop = op; req_funct = f; req_a = a; req_b = b;
    check("req_ready_idle", {31'd0, req_ready}, 1);
    @(posedge clk);  // accept edge N
    #1 req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom;
    @(negedge clk);
    if (legal) begin
      check("exec_gin", {29'd0, alu_gin}, {29'd0, gin});
      check("exec_a", alu_a, a);
      check("exec_b", alu_b, b);
      check("exec_rsp_valid", {31'd0, rsp_valid}, 0);
      check("exec_req_ready", {31'd0, req_ready}, 0);
      @(negedge clk);
    end else begin
      check("illegal_gin", {29'd0, alu_gin}, 3'b010);
    end
    e = exp_q.pop_front();
    check("rsp_valid", {31'd0, rsp_valid}, 1);
    check("rsp_result", rsp_result, e[W-1:0]);
    check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e[W]});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e[W+1]});
    for (int i = 0; i < hold; i++) begin
      // Requests offered while a response is pending must be ignored.
      req_valid = 1'b1; req_aluop = 2'b00; req_a = $urandom; req_b = $urandom;
      @(negedge clk);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 1);
      check("hold_req_ready", {31'd0, req_ready}, 0);
      check("hold_result", rsp_result, e[W-1:0]);
      check("hold_err", {31'd0, rsp_err}, {31'd0, e[W+1]});
      check("hold_gin", {29'd0, alu_gin}, 3'b010);
    end
    req_valid = overlap;
    rsp_ready = 1'b1;
    @(posedge clk);  // response transfer edge
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("post_rsp_valid", {31'd0, rsp_valid}, 0);
    check("post_req_ready", {31'd0, req_ready}, 1);
    check("post_gin", {29'd0, alu_gin}, 3'b010);
`ifdef ALU_OP_SEQUENCER_CHECK_EN
    check("chk_mismatch", {31'd0, chk_mismatch}, 0);
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [5:0] functs [6];
    logic [1:0] op;
    logic [5:0] f;
    logic [W-1:0] a, b;
    functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
    functs[3] = 6'h25; functs[4] = 6'h2A; functs[5] = 6'h00;

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_aluop = '0; req_funct = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 0);
    check("reset_result", rsp_result, 0);
    check("reset_zero", {31'd0, rsp_zero}, 0);
    check("reset_err", {31'd0, rsp_err}, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    check("reset_gin", {29'd0, alu_gin}, 3'b010);

    // Directed cases.
    run_txn(2'b10, 6'h20, 32'd5, 32'd7, 0, 0);
    run_txn(2'b01, 6'h00, 32'h10, 32'h10, 0, 0);
    run_txn(2'b10, 6'h22, 32'd0, 32'd1, 0, 0);
    run_txn(2'b10, 6'h2A, 32'hFFFF_FFFE, 32'd1, 0, 0);
    run_txn(2'b10, 6'h2A, 32'd3, 32'd2, 0, 0);
    run_txn(2'b10, 6'h2A, 32'h8000_0000, 32'd1, 0, 0);  // signed overflow passthrough
    run_txn(2'b10, 6'h27, 32'd9, 32'd9, 0, 0);
    run_txn(2'b11, 6'h20, 32'd9, 32'd9, 0, 0);
    run_txn(2'b00, 6'h3F, 32'hFFFF_FFFF, 32'd1, 0, 0);  // wrap to zero
    // Backpressure for 5 cycles, then a request waiting on the release edge.
    run_txn(2'b10, 6'h24, 32'h1234_5678, 32'h0F0F_0F0F, 5, 1);
    run_txn(2'b10, 6'h25, 32'h00F0, 32'h0F00, 0, 0);

    // Reset during EXEC of an AND: transaction dropped, no response.
    req_valid = 1'b1; req_aluop = 2'b10; req_funct = 6'h24;
    req_a = 32'hF0F0; req_b = 32'hFF00;
    @(posedge clk);
    #1 req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rst_mid_exec_gin", {29'd0, alu_gin}, 3'b000);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_mid_req_ready", {31'd0, req_ready}, 1);
    check("rst_mid_gin", {29'd0, alu_gin}, 3'b010);
    check("rst_mid_alu_a", alu_a, 0);
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_drop_rsp_valid", {31'd0, rsp_valid}, 0);
    end
    rsp_ready = 1'b0;
    run_txn(2'b10, 6'h25, 32'hF0F0, 32'h0F0F, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      f  = functs[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) f = 6'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      run_txn(op, f, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;
    @(negedge clk);

`ifdef ALU_OP_SEQUENCER_CHECK_EN
    check("chk_mismatch_final", {31'd0, chk_mismatch}, 0);
`endif
    check("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
